// File: rtl/rfsoc_load_sequencer.sv
// rtl/rfsoc_load_sequencer.sv - RFSoC waveform controller load and fire sequencer
//
// Purpose:
//    Accepts parallel command words and shifts each one MSB first onto the
//    wave, delay or idle register chain with a generated serial clock.
//    A wave word flagged last is followed by one wave parallel-load clock
//    pulse. On start it raises arm, waits ARM_SETTLE cycles and then pulses
//    fire for one cycle. Afterwards it stays armed until disarm.
//
// Ports:
//    clk_in                 sole clock, rising edge
//    reset                  asynchronous active-low reset
//    s_valid/s_ready        command handshake (s_ready is combinational)
//    s_target               0=wave 1=delay 2=idle 3=reserved
//    s_data                 word to shift, MSB first
//    s_last                 final wave word, adds a pclk pulse
//    start, disarm          arm/fire sequence control
//    wave_reg_*             wave chain serial clock, load clock, data
//    delay_reg_*            delay chain serial clock, data
//    idle_reg_*             idle chain serial clock, data
//    arm, fire              fire controller arm level and fire strobe
//    busy                   sequencer not idle
//    err                    sticky, reserved target accepted

module rfsoc_load_sequencer #(
   parameter int WORD_W     = 32,
   parameter int CLK_DIV    = 4,
   parameter int ARM_SETTLE = 16
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [1:0]        s_target,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_last,
   input  logic              start,
   input  logic              disarm,
   output logic              wave_reg_sclk,
   output logic              wave_reg_pclk,
   output logic              wave_reg_data_in,
   output logic              delay_reg_sclk,
   output logic              delay_reg_data_in,
   output logic              idle_reg_sclk,
   output logic              idle_reg_data_in,
   output logic              arm,
   output logic              fire,
   output logic              busy,
   output logic              err
);

   localparam int DIV_W = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
   localparam int SET_W = (ARM_SETTLE > 1) ? $clog2(ARM_SETTLE) : 1;
   localparam int BIT_W = (WORD_W > 1)     ? $clog2(WORD_W)     : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(ARM_SETTLE - 1);
   localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(WORD_W - 1);

   localparam logic [1:0] TGT_WAVE  = 2'd0;
   localparam logic [1:0] TGT_DELAY = 2'd1;
   localparam logic [1:0] TGT_IDLE  = 2'd2;
   localparam logic [1:0] TGT_RSVD  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SHIFT_LO = 3'd1,
      ST_SHIFT_HI = 3'd2,
      ST_PCLK_HI  = 3'd3,
      ST_PCLK_LO  = 3'd4,
      ST_ARM_WAIT = 3'd5,
      ST_FIRE     = 3'd6,
      ST_ARMED    = 3'd7
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [DIV_W-1:0]  r_div_cnt;
   logic [DIV_W-1:0]  w_next_div_cnt;
   logic [SET_W-1:0]  r_settle_cnt;
   logic [SET_W-1:0]  w_next_settle_cnt;
   logic [BIT_W-1:0]  r_bit_cnt;
   logic [BIT_W-1:0]  w_next_bit_cnt;
   logic [WORD_W-1:0] r_shift;
   logic [WORD_W-1:0] w_next_shift;
   logic [1:0]        r_target;
   logic [1:0]        w_next_target;
   logic              r_last;
   logic              w_next_last;

   logic              w_accept;

   // Registered outputs and the values they take on the next edge
   logic r_wave_sclk,  w_wave_sclk;
   logic r_wave_pclk,  w_wave_pclk;
   logic r_wave_data,  w_wave_data;
   logic r_delay_sclk, w_delay_sclk;
   logic r_delay_data, w_delay_data;
   logic r_idle_sclk,  w_idle_sclk;
   logic r_idle_data,  w_idle_data;
   logic r_arm,        w_arm;
   logic r_fire,       w_fire;
   logic r_busy,       w_busy;
   logic r_err,        w_err;

   // start takes priority over a pending command word in IDLE
   assign s_ready  = (r_state == ST_IDLE) && !start;
   assign w_accept = s_valid && s_ready;

   // ---------------------------------------------------------------
   // State and datapath register
   // ---------------------------------------------------------------
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_div_cnt    <= '0;
         r_settle_cnt <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_target     <= TGT_WAVE;
         r_last       <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_div_cnt    <= w_next_div_cnt;
         r_settle_cnt <= w_next_settle_cnt;
         r_bit_cnt    <= w_next_bit_cnt;
         r_shift      <= w_next_shift;
         r_target     <= w_next_target;
         r_last       <= w_next_last;
      end
   end

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      w_next_state      = r_state;
      w_next_div_cnt    = r_div_cnt;
      w_next_settle_cnt = r_settle_cnt;
      w_next_bit_cnt    = r_bit_cnt;
      w_next_shift      = r_shift;
      w_next_target     = r_target;
      w_next_last       = r_last;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next_state      = ST_ARM_WAIT;
               w_next_settle_cnt = '0;
            end else if (w_accept && (s_target != TGT_RSVD)) begin
               // Reserved-target words are swallowed without leaving IDLE
               w_next_state   = ST_SHIFT_LO;
               w_next_div_cnt = '0;
               w_next_bit_cnt = BIT_MSB;
               w_next_shift   = s_data;
               w_next_target  = s_target;
               w_next_last    = s_last;
            end
         end

         ST_SHIFT_LO: begin
            if (r_div_cnt == DIV_LAST) begin
               w_next_div_cnt = '0;
               w_next_state   = ST_SHIFT_HI;
            end else begin
               w_next_div_cnt = r_div_cnt + DIV_W'(1);
            end
         end

         ST_SHIFT_HI: begin
            if (r_div_cnt == DIV_LAST) begin
               w_next_div_cnt = '0;
               if (r_bit_cnt == '0) begin
                  if ((r_target == TGT_WAVE) && r_last)
                     w_next_state = ST_PCLK_HI;
                  else
                     w_next_state = ST_IDLE;
               end else begin
                  // Advance the bit only as sclk falls so data holds a full high phase
                  w_next_bit_cnt = r_bit_cnt - BIT_W'(1);
                  w_next_shift   = {r_shift[WORD_W-2:0], 1'b0};
                  w_next_state   = ST_SHIFT_LO;
               end
            end else begin
               w_next_div_cnt = r_div_cnt + DIV_W'(1);
            end
         end

         ST_PCLK_HI: begin
            if (r_div_cnt == DIV_LAST) begin
               w_next_div_cnt = '0;
               w_next_state   = ST_PCLK_LO;
            end else begin
               w_next_div_cnt = r_div_cnt + DIV_W'(1);
            end
         end

         ST_PCLK_LO: begin
            if (r_div_cnt == DIV_LAST) begin
               w_next_div_cnt = '0;
               w_next_state   = ST_IDLE;
            end else begin
               w_next_div_cnt = r_div_cnt + DIV_W'(1);
            end
         end

         ST_ARM_WAIT: begin
            if (disarm) begin
               w_next_state = ST_IDLE;
            end else if (r_settle_cnt == SET_LAST) begin
               w_next_state = ST_FIRE;
            end else begin
               w_next_settle_cnt = r_settle_cnt + SET_W'(1);
            end
         end

         ST_FIRE: begin
            w_next_state = ST_ARMED;
         end

         ST_ARMED: begin
            // disarm wins over a simultaneous re-fire request
            if (disarm)
               w_next_state = ST_IDLE;
            else if (start)
               w_next_state = ST_FIRE;
         end

         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Output logic: decoded from the next state so every output pin is
   // driven straight from a flop and the generated clocks cannot glitch.
   // ---------------------------------------------------------------
   logic w_shifting;
   logic w_sclk_hi;
   logic w_bit;

   always_comb begin
      w_shifting = (w_next_state == ST_SHIFT_LO) || (w_next_state == ST_SHIFT_HI);
      w_sclk_hi  = (w_next_state == ST_SHIFT_HI);
      w_bit      = w_shifting && w_next_shift[WORD_W-1];

      w_wave_sclk  = w_sclk_hi && (w_next_target == TGT_WAVE);
      w_wave_data  = w_bit     && (w_next_target == TGT_WAVE);
      w_delay_sclk = w_sclk_hi && (w_next_target == TGT_DELAY);
      w_delay_data = w_bit     && (w_next_target == TGT_DELAY);
      w_idle_sclk  = w_sclk_hi && (w_next_target == TGT_IDLE);
      w_idle_data  = w_bit     && (w_next_target == TGT_IDLE);
      w_wave_pclk  = (w_next_state == ST_PCLK_HI);

      w_arm  = (w_next_state == ST_ARM_WAIT) || (w_next_state == ST_FIRE) ||
               (w_next_state == ST_ARMED);
      w_fire = (w_next_state == ST_FIRE);
      w_busy = (w_next_state != ST_IDLE);
      w_err  = r_err || (w_accept && (s_target == TGT_RSVD));
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_wave_sclk  <= 1'b0;
         r_wave_pclk  <= 1'b0;
         r_wave_data  <= 1'b0;
         r_delay_sclk <= 1'b0;
         r_delay_data <= 1'b0;
         r_idle_sclk  <= 1'b0;
         r_idle_data  <= 1'b0;
         r_arm        <= 1'b0;
         r_fire       <= 1'b0;
         r_busy       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_wave_sclk  <= w_wave_sclk;
         r_wave_pclk  <= w_wave_pclk;
         r_wave_data  <= w_wave_data;
         r_delay_sclk <= w_delay_sclk;
         r_delay_data <= w_delay_data;
         r_idle_sclk  <= w_idle_sclk;
         r_idle_data  <= w_idle_data;
         r_arm        <= w_arm;
         r_fire       <= w_fire;
         r_busy       <= w_busy;
         r_err        <= w_err;
      end
   end

   assign wave_reg_sclk     = r_wave_sclk;
   assign wave_reg_pclk     = r_wave_pclk;
   assign wave_reg_data_in  = r_wave_data;
   assign delay_reg_sclk    = r_delay_sclk;
   assign delay_reg_data_in = r_delay_data;
   assign idle_reg_sclk     = r_idle_sclk;
   assign idle_reg_data_in  = r_idle_data;
   assign arm               = r_arm;
   assign fire              = r_fire;
   assign busy              = r_busy;
   assign err               = r_err;

endmodule

// File: doc/rfsoc_load_sequencer.md
# rfsoc_load_sequencer

Sequences the programming and firing of the RFSoC waveform controller from one `clk_in` domain. It accepts parallel words on a valid/ready command port and serialises each one, MSB first, onto the wave, delay or idle register chains with generated serial clocks. After the last wave word it issues the wave parallel-load clock. On request it drives `arm`, waits a settle time, then issues the single-cycle `fire` strobe the fire controller requires.

## Interface
Parameters:
- WORD_W, 32, bits per command word shifted into a chain
- CLK_DIV, 4, clk_in cycles per serial-clock half period (≥1)
- ARM_SETTLE, 16, clk_in cycles between `arm` rising and the `fire` strobe (≥1)

Ports:
- clk_in  in  1  sole clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low; asserts immediately, deasserts on clk_in edge
- s_valid  in  1  command word present
- s_ready  out  1  command accepted when s_valid&&s_ready
- s_target  in  2  0=wave, 1=delay, 2=idle, 3=reserved
- s_data  in  WORD_W  word to shift, MSB first
- s_last  in  1  final wave word; triggers pclk pulse (ignored for other targets)
- start  in  1  request arm+fire sequence
- disarm  in  1  leave armed state
- wave_reg_sclk, wave_reg_pclk, wave_reg_data_in  out  1 each
- delay_reg_sclk, delay_reg_data_in  out  1 each
- idle_reg_sclk, idle_reg_data_in  out  1 each
- arm  out  1  arm / cycle-mode select to the controller
- fire  out  1  one-cycle fire strobe
- busy  out  1  state ≠ IDLE
- err  out  1  sticky: reserved target was accepted

## Operation
- States: IDLE, SHIFT_LO, SHIFT_HI, PCLK_HI, PCLK_LO, ARM_WAIT, FIRE, ARMED.
- s_ready = (state==IDLE) && !start, combinational. start has priority over s_valid in IDLE.
- Accept: latch data, target, last, and bit counter = WORD_W-1, then go to SHIFT_LO.
- SHIFT_LO: the selected sclk is low and data_in = current bit, for CLK_DIV cycles. Then SHIFT_HI: sclk is high for CLK_DIV cycles with data unchanged. Then decrement the bit counter and repeat. After bit 0 completes SHIFT_HI, go to PCLK_HI if target=wave and last, else to IDLE.
- Only the selected chain's sclk/data toggle. All other sclk/data outputs hold 0.
- PCLK_HI: wave_reg_pclk=1 for CLK_DIV cycles. PCLK_LO: 0 for CLK_DIV cycles. Then go to IDLE.
- Target 3: the word is accepted and no output toggles. err is set the next cycle. State stays IDLE.
- start in IDLE goes to ARM_WAIT: arm=1 and the counter runs ARM_SETTLE cycles. Then FIRE: fire=1 for exactly one cycle. Then ARMED with arm held at 1.
- In ARMED, start triggers FIRE again (fire one cycle, arm stays 1). disarm goes to IDLE with arm=0 on the next cycle. If both are asserted, disarm wins.
- disarm during ARM_WAIT aborts: go to IDLE, arm=0, no fire.
- start and disarm are ignored during shifting and pclk states. Commands stall (s_ready=0) while not IDLE.
- err clears only on reset.

## Timing
- All outputs are registered, so generated clocks are glitch-free. s_ready is the only combinational output.
- Reset values: all sclk, pclk, data_in, arm, fire, busy and err are 0, and state is IDLE.
- Reset mid-shift: outputs go to 0 immediately and the word is abandoned. Downstream chains keep the partial bits.
- Word accepted on cycle N:
  - busy=1, sclk=0 and data=MSB from N+1.
  - First sclk rising edge at N+1+CLK_DIV.
  - Word occupies 2·CLK_DIV·WORD_W cycles.
  - IDLE, and s_ready high, at N+1+2·CLK_DIV·WORD_W.
  - If a pclk pulse follows, add 2·CLK_DIV cycles.
- Data changes only on sclk falling transitions, so setup and hold are each ≥CLK_DIV cycles.
- start sampled at cycle S: arm=1 at S+1, fire=1 at S+1+ARM_SETTLE for one cycle, ARMED from the cycle after fire.
- Back-to-back commands: next acceptance is possible in the first IDLE cycle, so there are no gaps beyond the return to IDLE.

## Test plan
Bench settings: WORD_W=8, CLK_DIV=2, ARM_SETTLE=4.
- Delay word 0xA5 accepted at N → delay_reg_sclk rises at N+3, N+7, …, N+31; sampled bits are 1,0,1,0,0,1,0,1; wave/idle outputs stay 0; s_ready=1 at N+33.
- Wave word 0x3C with s_last=1 at N → 8 wave sclk pulses with bits 0,0,1,1,1,1,0,0; wave_reg_pclk high at N+33..N+34; IDLE at N+37.
- start at S → arm=1 from S+1; fire=1 only at S+5; arm stays 1; a second start in ARMED gives a one-cycle fire the next cycle; disarm → arm=0 the next cycle.
- disarm at S+2 after start at S → arm=0 at S+3, fire never asserts.
- s_target=3 with data 0xFF → no sclk toggles, err=1 the next cycle and stays 1; a following idle word shifts normally.
- reset asserted at N+10 mid-word → all outputs 0 the same cycle; after release, s_ready=1 and a new word shifts from its MSB.
